alarm_controller: RTL and testbench

//  Downstream consumer of the running BCD time (hh:mm:ss counters + 10 Hz tick) of the digital clock.

---
 rtl/alarm_controller_pkg.sv | 12 +
 rtl/alarm_time_reg.sv | 36 +++
 rtl/alarm_controller.sv | 86 ++++++++
 tb/tb_alarm_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_controller_pkg.sv
// alarm_controller_pkg: shared state encoding and BCD digit widths/limits
package alarm_controller_pkg;
  typedef enum logic [1:0] {IDLE, SET, ARMED, RINGING} state_t;
  localparam int MU_W = 4;
  localparam int MT_W = 3;
  localparam int HU_W = 4;
  localparam int HT_W = 2;
  localparam logic [3:0] MAX_U  = 4'd9;
  localparam logic [2:0] MAX_MT = 3'd5;
  localparam logic [1:0] MAX_HT = 2'd2;
  localparam logic [3:0] MAX_HU = 4'd3;
endpackage

// File: rtl/alarm_time_reg.sv
// alarm_time_reg: BCD hh:mm register with minute/hour stepping and 23:59 wrap
module alarm_time_reg
  import alarm_controller_pkg::*;
#(
  parameter int DEF_HOUR = 6,
  parameter int DEF_MIN  = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step_min,
  input  logic            step_hr,
  output logic [MU_W-1:0] m_u,
  output logic [MT_W-1:0] m_t,
  output logic [HU_W-1:0] h_u,
  output logic [HT_W-1:0] h_t
);
  logic hr_top;
  assign hr_top = h_t == MAX_HT && h_u == MAX_HU;
  always_ff @(posedge clk) begin
    if (reset) begin
      m_u <= MU_W'(DEF_MIN % 10);
      m_t <= MT_W'(DEF_MIN / 10);
      h_u <= HU_W'(DEF_HOUR % 10);
      h_t <= HT_W'(DEF_HOUR / 10);
    end else begin
      if (step_min) begin
        m_u <= m_u == MAX_U ? '0 : m_u + 1'b1;
        if (m_u == MAX_U) m_t <= m_t == MAX_MT ? '0 : m_t + 1'b1;
      end
      if (step_hr) begin
        h_u <= (hr_top || h_u == MAX_U) ? '0 : h_u + 1'b1;
        h_t <= hr_top ? '0 : h_u == MAX_U ? h_t + 1'b1 : h_t;
      end
    end
  end
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: alarm set/arm/ring FSM with time compare and beep timer
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int RING_TICKS = 600,
  parameter int BEEP_TICKS = 5,
  parameter int DEF_HOUR   = 6,
  parameter int DEF_MIN    = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            Set_Alarm,
  input  logic            Alarm_Off,
  input  logic            MIN,
  input  logic            HR,
  input  logic [MU_W-1:0] time_m_u,
  input  logic [MT_W-1:0] time_m_t,
  input  logic [HU_W-1:0] time_h_u,
  input  logic [HT_W-1:0] time_h_t,
  output logic [MU_W-1:0] alarm_m_u,
  output logic [MT_W-1:0] alarm_m_t,
  output logic [HU_W-1:0] alarm_h_u,
  output logic [HT_W-1:0] alarm_h_t,
  output logic            armed,
  output logic            ringing,
  output logic            Alarm_Out
);
  localparam int RW = $clog2(RING_TICKS);
  localparam int BW = $clog2(BEEP_TICKS);
  state_t state, state_n;
  logic off_q, match_q, match, off_rise, timeout, entering, ring_tick, beep_wrap, phase, phase_n;
  logic [RW-1:0] ring_cnt, ring_n;
  logic [BW-1:0] beep_cnt, beep_n;
  alarm_time_reg #(.DEF_HOUR(DEF_HOUR), .DEF_MIN(DEF_MIN)) u_time (
    .clk     (clk),
    .reset   (reset),
    .step_min(state == SET && tick && MIN),
    .step_hr (state == SET && tick && HR),
    .m_u     (alarm_m_u),
    .m_t     (alarm_m_t),
    .h_u     (alarm_h_u),
    .h_t     (alarm_h_t)
  );
  assign match = {time_h_t, time_h_u, time_m_t, time_m_u} == {alarm_h_t, alarm_h_u, alarm_m_t, alarm_m_u};
  assign off_rise = Alarm_Off & ~off_q;
  assign ring_tick = state == RINGING && tick;
  assign timeout = ring_tick && ring_cnt == RW'(RING_TICKS - 1);
  assign beep_wrap = beep_cnt == BW'(BEEP_TICKS - 1);
  assign armed = state == ARMED || state == RINGING;
  assign ringing = state == RINGING;
  always_comb begin
    state_n = state;
    if (Set_Alarm) state_n = SET;
    else
      case (state)
        IDLE:    state_n = off_rise ? ARMED : IDLE;
        SET:     state_n = ARMED;
        ARMED:   state_n = off_rise ? IDLE : (match && !match_q) ? RINGING : ARMED;
        default: state_n = (off_rise || timeout) ? ARMED : RINGING;
      endcase
    entering = state_n == RINGING && state != RINGING;
    ring_n = entering ? '0 : (ring_tick && !timeout) ? ring_cnt + 1'b1 : ring_cnt;
    beep_n = entering ? '0 : ring_tick ? (beep_wrap ? '0 : beep_cnt + 1'b1) : beep_cnt;
    phase_n = entering ? 1'b1 : (ring_tick && beep_wrap) ? ~phase : phase;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      off_q <= 1'b0;
      match_q <= 1'b0;
      ring_cnt <= '0;
      beep_cnt <= '0;
      phase <= 1'b0;
      Alarm_Out <= 1'b0;
    end else begin
      state <= state_n;
      off_q <= Alarm_Off;
      match_q <= match;
      ring_cnt <= ring_n;
      beep_cnt <= beep_n;
      phase <= phase_n;
      Alarm_Out <= state_n == RINGING && phase_n;
    end
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed stimulus with a queued-expectation scoreboard
module tb_alarm_controller;
  logic clk = 0, reset = 1, tick = 0, Set_Alarm = 0, Alarm_Off = 0, MIN = 0, HR = 0;
  logic [3:0] time_m_u, time_h_u, alarm_m_u, alarm_h_u;
  logic [2:0] time_m_t, alarm_m_t;
  logic [1:0] time_h_t, alarm_h_t;
  logic armed, ringing, Alarm_Out;
  int t_h = 6, t_m = 30;
  int vectors = 0, errors = 0;
  typedef struct {
    string name;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];

  assign time_h_t = 2'(t_h / 10);
  assign time_h_u = 4'(t_h % 10);
  assign time_m_t = 3'(t_m / 10);
  assign time_m_u = 4'(t_m % 10);

  alarm_controller dut (
    .clk(clk), .reset(reset), .tick(tick), .Set_Alarm(Set_Alarm), .Alarm_Off(Alarm_Off),
    .MIN(MIN), .HR(HR), .time_m_u(time_m_u), .time_m_t(time_m_t), .time_h_u(time_h_u),
    .time_h_t(time_h_t), .alarm_m_u(alarm_m_u), .alarm_m_t(alarm_m_t), .alarm_h_u(alarm_h_u),
    .alarm_h_t(alarm_h_t), .armed(armed), .ringing(ringing), .Alarm_Out(Alarm_Out)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    errors++;
    $display("FAIL timeout: simulation did not complete within 1 ms");
    $finish;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      tick = 1;
      step();
      tick = 0;
      step();
    end
  endtask

  task automatic chk(input string name, input int h, input int m, input bit a, input bit r, input bit o);
    exp_t e;
    e.name = name;
    e.v = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), a, r, o};
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = {alarm_h_t, alarm_h_u, alarm_m_t, alarm_m_u, armed, ringing, Alarm_Out};
        vectors++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got hh:mm=%h%h:%h%h armed=%b ringing=%b out=%b, want %h%h:%h%h armed=%b ringing=%b out=%b",
                   e.name, act[15:14], act[13:10], act[9:7], act[6:3], act[2], act[1], act[0],
                   e.v[15:14], e.v[13:10], e.v[9:7], e.v[6:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin
    step(2);
    reset = 0;
    vectors++;
    if (armed !== 1'b0 || ringing !== 1'b0 || Alarm_Out !== 1'b0) begin
      errors++;
      $display("FAIL reset_direct: armed=%b ringing=%b out=%b", armed, ringing, Alarm_Out);
    end
    chk("reset", 6, 30, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      pulse_ticks(1);
      chk("idle_ignores_match", 6, 30, 0, 0, 0);
    end
    Set_Alarm = 1;
    step();
    chk("set_entry", 6, 30, 0, 0, 0);
    MIN = 1;
    pulse_ticks(31);
    MIN = 0;
    chk("min_x31", 6, 1, 0, 0, 0);
    HR = 1;
    pulse_ticks(18);
    HR = 0;
    chk("hr_x18", 0, 1, 0, 0, 0);
    MIN = 1;
    HR = 1;
    step(3);
    chk("no_step_without_tick", 0, 1, 0, 0, 0);
    MIN = 0;
    pulse_ticks(7);
    HR = 0;
    MIN = 1;
    pulse_ticks(14);
    MIN = 0;
    chk("set_0715", 7, 15, 0, 0, 0);
    t_h = 7;
    t_m = 14;
    Set_Alarm = 0;
    step();
    chk("armed", 7, 15, 1, 0, 0);
    t_m = 15;
    step();
    chk("ring_start", 7, 15, 1, 1, 1);
    for (int k = 1; k <= 600; k++) begin
      pulse_ticks(1);
      if (k == 600) chk("ring_timeout", 7, 15, 1, 0, 0);
      else if (k <= 12 || k >= 596) chk("beep_phase", 7, 15, 1, 1, ((k / 5) % 2) == 0);
    end
    step(3);
    chk("no_retrigger", 7, 15, 1, 0, 0);
    t_m = 16;
    step();
    t_m = 15;
    step();
    chk("ring_again", 7, 15, 1, 1, 1);
    Alarm_Off = 1;
    step();
    chk("off_silences", 7, 15, 1, 0, 0);
    step(3);
    chk("off_held_stays_armed", 7, 15, 1, 0, 0);
    Alarm_Off = 0;
    step();
    Alarm_Off = 1;
    step();
    chk("off_disarms", 7, 15, 0, 0, 0);
    Alarm_Off = 0;
    step();
    Alarm_Off = 1;
    step();
    chk("off_rearms", 7, 15, 1, 0, 0);
    Alarm_Off = 0;
    t_m = 16;
    step();
    t_m = 15;
    step();
    chk("ring_before_set", 7, 15, 1, 1, 1);
    Set_Alarm = 1;
    step();
    chk("set_midring", 7, 15, 0, 0, 0);
    Set_Alarm = 0;
    step(2);
    chk("set_exit_no_ring", 7, 15, 1, 0, 0);
    t_m = 16;
    step();
    t_m = 15;
    step();
    chk("ring_before_reset", 7, 15, 1, 1, 1);
    reset = 1;
    step();
    reset = 0;
    chk("reset_midring", 6, 30, 0, 0, 0);
    Set_Alarm = 1;
    step();
    HR = 1;
    pulse_ticks(17);
    HR = 0;
    chk("hr_to_23", 23, 30, 0, 0, 0);
    MIN = 1;
    pulse_ticks(29);
    chk("min_to_59", 23, 59, 0, 0, 0);
    pulse_ticks(1);
    MIN = 0;
    chk("min_wrap", 23, 0, 0, 0, 0);
    HR = 1;
    pulse_ticks(1);
    chk("hr_wrap", 0, 0, 0, 0, 0);
    MIN = 1;
    pulse_ticks(1);
    chk("min_hr_together", 1, 1, 0, 0, 0);
    Set_Alarm = 0;
    step();
    pulse_ticks(2);
    chk("no_step_when_armed", 1, 1, 1, 0, 0);
    MIN = 0;
    HR = 0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
